vga_hit_probe: RTL and testbench

- Reader at the far end of the vga_if pixel stream. It observes a fully composed frame, such as the output of the sprite draw chain, and samples the RGB value at one aimed pixel.
- On a trigger (mouse click or shot), it waits for the next frame start, captures the pixel at (aim_x, aim_y), compares the pixel against a key colour under a mask, and reports hit or miss with a one-cycle valid pulse.
- Sits in parallel with the final VGA output stage and feeds the game logic (score and duck state).

---
 rtl/vga_hit_probe_if.sv | 14 +
 rtl/vga_hit_probe.sv | 136 +++++++++++++
 tb/tb_vga_hit_probe.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_hit_probe_if.sv
// Pixel stream bundle passed between VGA pipeline stages.
// The "in" modport is the consumer view, "out" the producer view.
interface vga_if;
   logic [10:0] vcount;
   logic [10:0] hcount;
   logic        vsync;
   logic        vblnk;
   logic        hsync;
   logic        hblnk;
   logic [11:0] rgb;

   modport in  (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
   modport out (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/vga_hit_probe.sv
// Samples one aimed pixel of the next full frame after a trigger and
// reports hit/miss against a masked key colour, with a frame timeout.
module vga_hit_probe #(
   parameter logic [11:0] TARGET_RGB     = 12'h000,
   parameter logic [11:0] TARGET_MASK    = 12'hFFF,
   parameter int          TIMEOUT_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst,
   vga_if.in           in,
   input  logic        trigger,
   input  logic [11:0] aim_x,
   input  logic [11:0] aim_y,
   output logic        busy,
   output logic        result_valid,
   output logic        hit,
   output logic        timeout,
   output logic [11:0] sampled_rgb
);

   localparam int              CW          = $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [CW-1:0]   TIMEOUT_CNT = CW'(TIMEOUT_FRAMES);
   localparam logic [11:0]     TARGET_KEY  = TARGET_RGB & TARGET_MASK;

   typedef enum logic [1:0] {IDLE, ARM, SCAN, DONE} state_t;

   state_t        state_reg, state_next;
   logic [11:0]   ax_reg, ax_next;
   logic [11:0]   ay_reg, ay_next;
   logic [CW-1:0] frame_cnt_reg, frame_cnt_next;
   logic [CW-1:0] frame_cnt_inc;
   logic          busy_reg, busy_next;
   logic          valid_reg, valid_next;
   logic          hit_reg, hit_next;
   logic          timeout_reg, timeout_next;
   logic [11:0]   rgb_reg, rgb_next;

   logic          frame_start;
   logic          coord_match;
   logic          unused_sync;

   // Sync pulses are part of the bundle but carry nothing the probe needs.
   assign unused_sync = in.vsync ^ in.hsync;

   assign frame_start   = (in.vcount == 11'd0) && (in.hcount == 11'd0);
   assign coord_match   = ({1'b0, in.hcount} == ax_reg) && ({1'b0, in.vcount} == ay_reg);
   assign frame_cnt_inc = (&frame_cnt_reg) ? frame_cnt_reg : frame_cnt_reg + 1'b1;

   always_comb begin
      state_next     = state_reg;
      ax_next        = ax_reg;
      ay_next        = ay_reg;
      frame_cnt_next = frame_cnt_reg;
      hit_next       = hit_reg;
      timeout_next   = timeout_reg;
      rgb_next       = rgb_reg;

      case (state_reg)
         IDLE: begin
            if (trigger) begin
               ax_next        = aim_x;
               ay_next        = aim_y;
               frame_cnt_next = '0;
               state_next     = ARM;
            end
         end
         ARM: begin
            if (frame_start) begin
               state_next = SCAN;
            end
         end
         SCAN: begin
            if (frame_start) begin
               frame_cnt_next = frame_cnt_inc;
            end
            if (coord_match) begin
               timeout_next = 1'b0;
               state_next   = DONE;
               if (!in.hblnk && !in.vblnk) begin
                  rgb_next = in.rgb;
                  hit_next = ((in.rgb & TARGET_MASK) == TARGET_KEY);
               end else begin
                  rgb_next = 12'h000;
                  hit_next = 1'b0;
               end
            end else if (frame_start && (frame_cnt_inc >= TIMEOUT_CNT)) begin
               // Aim point never appeared within the allowed number of frames.
               rgb_next     = 12'h000;
               hit_next     = 1'b0;
               timeout_next = 1'b1;
               state_next   = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next  = (state_next == ARM) || (state_next == SCAN);
      valid_next = (state_next == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         ax_reg        <= '0;
         ay_reg        <= '0;
         frame_cnt_reg <= '0;
         busy_reg      <= 1'b0;
         valid_reg     <= 1'b0;
         hit_reg       <= 1'b0;
         timeout_reg   <= 1'b0;
         rgb_reg       <= '0;
      end else begin
         state_reg     <= state_next;
         ax_reg        <= ax_next;
         ay_reg        <= ay_next;
         frame_cnt_reg <= frame_cnt_next;
         busy_reg      <= busy_next;
         valid_reg     <= valid_next;
         hit_reg       <= hit_next;
         timeout_reg   <= timeout_next;
         rgb_reg       <= rgb_next;
      end
   end

   assign busy         = busy_reg;
   assign result_valid = valid_reg;
   assign hit          = hit_reg;
   assign timeout      = timeout_reg;
   assign sampled_rgb  = rgb_reg;

endmodule

// File: tb/tb_vga_hit_probe.sv
// Directed bench for vga_hit_probe on a compact 64x40 timing (48x32 visible);
// the aimed pixel is painted into the generated stream.
module tb_vga_hit_probe;

   localparam int H_VIS   = 48;
   localparam int H_TOTAL = 64;
   localparam int V_VIS   = 32;
   localparam int V_TOTAL = 40;
   localparam int FRAME   = H_TOTAL * V_TOTAL;

   logic        clk = 1'b0;
   logic        rst;
   logic        trigger;
   logic [11:0] aim_x;
   logic [11:0] aim_y;
   logic        busy;
   logic        result_valid;
   logic        hit;
   logic        timeout;
   logic [11:0] sampled_rgb;

   vga_if vif ();

   vga_hit_probe dut (
      .clk          (clk),
      .rst          (rst),
      .in           (vif),
      .trigger      (trigger),
      .aim_x        (aim_x),
      .aim_y        (aim_y),
      .busy         (busy),
      .result_valid (result_valid),
      .hit          (hit),
      .timeout      (timeout),
      .sampled_rgb  (sampled_rgb)
   );

   always #5 clk = ~clk;

   int          h_pos;
   int          v_pos;
   int          paint_x = -1;
   int          paint_y = -1;
   logic [11:0] paint_rgb = 12'h000;

   int vectors_applied = 0;
   int miscompares     = 0;

   task automatic drive_stream();
      logic blank;
      blank       = (h_pos >= H_VIS) || (v_pos >= V_VIS);
      vif.hcount  = 11'(h_pos);
      vif.vcount  = 11'(v_pos);
      vif.hblnk   = (h_pos >= H_VIS);
      vif.vblnk   = (v_pos >= V_VIS);
      vif.hsync   = (h_pos >= 52) && (h_pos < 56);
      vif.vsync   = (v_pos >= 34) && (v_pos < 36);
      if ((h_pos == paint_x) && (v_pos == paint_y))
         vif.rgb = paint_rgb;
      else if (blank)
         vif.rgb = 12'h000;
      else
         vif.rgb = {4'(h_pos), 4'(v_pos), 4'h5};
   endtask

   // Stream changes 2 time units after each edge, so at edge+1 the stream
   // still shows the pixel the DUT sampled on that edge.
   initial begin
      h_pos = 0;
      v_pos = 0;
      drive_stream();
      forever begin
         @(posedge clk);
         #2;
         if (h_pos == H_TOTAL - 1) begin
            h_pos = 0;
            v_pos = (v_pos == V_TOTAL - 1) ? 0 : v_pos + 1;
         end else begin
            h_pos = h_pos + 1;
         end
         drive_stream();
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors_applied++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for result_valid after an accepted trigger and checks the result.
   task automatic wait_result(input int ax, input int ay, input logic exp_hit,
                              input logic exp_to, input logic [11:0] exp_rgb);
      int frames;
      bit got;
      bit busy_ok;
      frames  = 0;
      got     = 1'b0;
      busy_ok = 1'b1;
      for (int c = 0; c < 4 * FRAME; c++) begin
         step();
         if ((h_pos == 0) && (v_pos == 0)) frames++;
         if (result_valid) begin
            got = 1'b1;
            break;
         end
         if (!busy) busy_ok = 1'b0;
      end
      check("result_valid_seen", 32'(got), 32'd1);
      check("busy_while_pending", 32'(busy_ok), 32'd1);
      if (got) begin
         check("busy_low_at_result", 32'(busy), 32'd0);
         check("hit", 32'(hit), 32'(exp_hit));
         check("timeout", 32'(timeout), 32'(exp_to));
         check("sampled_rgb", 32'(sampled_rgb), 32'(exp_rgb));
         check("frames_to_result", 32'(frames), exp_to ? 32'd3 : 32'd1);
         check("result_x", 32'(h_pos), exp_to ? 32'd0 : 32'(ax));
         check("result_y", 32'(v_pos), exp_to ? 32'd0 : 32'(ay));
         $display("probe aim=(%0d,%0d) hit=%0d timeout=%0d rgb=%03h frames=%0d",
                  ax, ay, hit, timeout, sampled_rgb, frames);
      end
   endtask

   task automatic run_probe(input int wait_c, input int ax, input int ay, input logic [11:0] prgb,
                            input logic exp_hit, input logic exp_to, input logic [11:0] exp_rgb);
      repeat (wait_c) step();
      paint_x = ax;
      paint_y = ay;
      paint_rgb = prgb;
      aim_x   = 12'(ax);
      aim_y   = 12'(ay);
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      aim_x   = 12'hFFF;
      aim_y   = 12'hFFF;
      check("busy_after_trigger", 32'(busy), 32'd1);
      wait_result(ax, ay, exp_hit, exp_to, exp_rgb);
      step();
      check("valid_one_cycle", 32'(result_valid), 32'd0);
      check("hit_held", 32'(hit), 32'(exp_hit));
   endtask

   typedef struct {
      int          wait_c;
      int          ax;
      int          ay;
      logic [11:0] prgb;
      logic        exp_hit;
      logic        exp_to;
      logic [11:0] exp_rgb;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{700,  40,   20,   12'h000, 1'b1, 1'b0, 12'h000};  // key colour
      vecs[1] = '{300,  40,   20,   12'h4AF, 1'b0, 1'b0, 12'h4AF};  // other colour
      vecs[2] = '{50,   2000, 2000, 12'h000, 1'b0, 1'b1, 12'h000};  // never reached
      vecs[3] = '{900,  56,   10,   12'hFFF, 1'b0, 1'b0, 12'h000};  // horizontal blank
      vecs[4] = '{10,   20,   35,   12'hFFF, 1'b0, 1'b0, 12'h000};  // vertical blank
      vecs[5] = '{400,  47,   31,   12'h000, 1'b1, 1'b0, 12'h000};  // last visible pixel
      vecs[6] = '{100,  3,    0,    12'hF00, 1'b0, 1'b0, 12'hF00};  // first line
      vecs[7] = '{1200, 0,    1,    12'h001, 1'b0, 1'b0, 12'h001};  // one bit off key
      vecs[8] = '{0,    63,   39,   12'h000, 1'b0, 1'b0, 12'h000};  // last pixel, blank
      vecs[9] = '{20,   2088, 20,   12'h000, 1'b0, 1'b1, 12'h000};  // x beyond 11 bits

      rst     = 1'b1;
      trigger = 1'b0;
      aim_x   = 12'h000;
      aim_y   = 12'h000;
      repeat (3) step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(result_valid), 32'd0);
      check("rst_hit", 32'(hit), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_rgb", 32'(sampled_rgb), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_probe(vecs[i].wait_c, vecs[i].ax, vecs[i].ay, vecs[i].prgb,
                   vecs[i].exp_hit, vecs[i].exp_to, vecs[i].exp_rgb);
      end

      // Retrigger while busy is ignored; trigger during DONE ignored, next cycle accepted.
      repeat (500) step();
      paint_x = 40; paint_y = 20; paint_rgb = 12'h000;
      aim_x = 12'd40; aim_y = 12'd20; trigger = 1'b1;
      step();
      trigger = 1'b0;
      repeat (2) step();
      aim_x = 12'd0; aim_y = 12'd0; trigger = 1'b1;
      step();
      trigger = 1'b0;
      wait_result(40, 20, 1'b1, 1'b0, 12'h000);
      paint_x = 10; paint_y = 5; paint_rgb = 12'h0AB;
      aim_x = 12'd10; aim_y = 12'd5; trigger = 1'b1;
      step();
      check("done_trigger_ignored", 32'(busy), 32'd0);
      check("done_valid_dropped", 32'(result_valid), 32'd0);
      step();
      trigger = 1'b0;
      check("idle_trigger_accepted", 32'(busy), 32'd1);
      wait_result(10, 5, 1'b0, 1'b0, 12'h0AB);
      step();

      // Reset in SCAN: outputs clear at once, no stale result afterwards.
      begin
         bit seen;
         int extra_valid;
         paint_x = 40; paint_y = 20; paint_rgb = 12'h4AF;
         aim_x = 12'd40; aim_y = 12'd20; trigger = 1'b1;
         step();
         trigger = 1'b0;
         seen = 1'b0;
         for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            if ((h_pos == 0) && (v_pos == 0)) begin
               seen = 1'b1;
               break;
            end
         end
         check("frame_start_before_rst", 32'(seen), 32'd1);
         repeat (5) step();
         check("busy_before_rst", 32'(busy), 32'd1);
         #2 rst = 1'b1;
         #1;
         check("async_rst_busy", 32'(busy), 32'd0);
         check("async_rst_rgb", 32'(sampled_rgb), 32'd0);
         check("async_rst_hit", 32'(hit), 32'd0);
         check("async_rst_timeout", 32'(timeout), 32'd0);
         check("async_rst_valid", 32'(result_valid), 32'd0);
         repeat (2) step();
         rst = 1'b0;
         extra_valid = 0;
         for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            if (result_valid || busy) extra_valid++;
         end
         check("no_result_after_rst", 32'(extra_valid), 32'd0);
         run_probe(30, 40, 20, 12'h4AF, 1'b0, 1'b0, 12'h4AF);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
